// File: rtl/s_mem_pkg.sv
// s_mem_pkg: shared constants and enums for the s_memory arbiter.
package s_mem_pkg;
    localparam int NUM_REQ    = 3;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int RD_LATENCY = 2;
    localparam int MAX_LOCK   = 16;
    typedef enum logic [1:0] {REQ_POP, REQ_SHUF, REQ_DEC} req_idx_e;
    typedef enum logic {ARB, LOCKED} arb_state_e;
endpackage

// File: rtl/s_mem_arbiter_rr_picker.sv
// rr_picker: picks the first requester after the pointer, wrapping, as one-hot and index.
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        idx = '0;
        any = |req;
        // Walk from the farthest candidate back so the nearest one after ptr wins.
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
        end
        gnt = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: round-robin arbiter with atomic lock for the shared 256x8 s_memory,
// returning read data tagged to its issuer after a fixed pipeline latency.
module s_mem_arbiter #(
    parameter int NUM_REQ    = s_mem_pkg::NUM_REQ,
    parameter int ADDR_W     = s_mem_pkg::ADDR_W,
    parameter int DATA_W     = s_mem_pkg::DATA_W,
    parameter int RD_LATENCY = s_mem_pkg::RD_LATENCY,
    parameter int MAX_LOCK   = s_mem_pkg::MAX_LOCK
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      lock_err,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_data,
    output logic                      mem_wren,
    input  logic [DATA_W-1:0]         mem_q
);
    import s_mem_pkg::*;
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_LOCK + 1);
    arb_state_e state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, g_idx, pick_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic lock_err_q, lock_err_d, g_any, pick_any;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic mem_wren_q, mem_wren_d;
    logic [RD_LATENCY-1:0] rv_vld_q, rv_vld_d;
    logic [RD_LATENCY*IW-1:0] rv_idx_q, rv_idx_d;

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req(req), .ptr(ptr_q), .gnt(pick_gnt), .idx(pick_idx), .any(pick_any)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        lock_err_d = lock_err_q;
        gnt        = '0;
        g_any      = 1'b0;
        g_idx      = pick_idx;
        if (state_q == ARB) begin
            if (pick_any) begin
                gnt   = pick_gnt;
                g_any = 1'b1;
                ptr_d = pick_idx;
                if (lock[pick_idx]) begin
                    state_d = LOCKED;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
        end else begin
            g_idx = owner_q;
            // Watchdog wins over the owner: the expiring cycle carries no access.
            if (cnt_q == CW'(MAX_LOCK)) begin
                state_d    = ARB;
                lock_err_d = 1'b1;
            end else if (!req[owner_q]) begin
                state_d = ARB;
            end else begin
                gnt[owner_q] = 1'b1;
                g_any        = 1'b1;
                cnt_d        = cnt_q + CW'(1);
                if (!lock[owner_q]) state_d = ARB;
            end
        end
        mem_wren_d    = g_any & we[g_idx];
        mem_address_d = g_any ? addr[g_idx*ADDR_W +: ADDR_W] : mem_address_q;
        mem_data_d    = g_any ? wdata[g_idx*DATA_W +: DATA_W] : mem_data_q;
        rv_vld_d      = (rv_vld_q << 1) | RD_LATENCY'(g_any & ~we[g_idx]);
        rv_idx_d      = (rv_idx_q << IW) | (RD_LATENCY*IW)'(g_idx);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ARB;
            ptr_q         <= '0;
            owner_q       <= '0;
            cnt_q         <= '0;
            lock_err_q    <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            rv_vld_q      <= '0;
            rv_idx_q      <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            lock_err_q    <= lock_err_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
            rv_vld_q      <= rv_vld_d;
            rv_idx_q      <= rv_idx_d;
        end
    end

    assign rvalid      = rv_vld_q[RD_LATENCY-1] ? NUM_REQ'(1) << rv_idx_q[(RD_LATENCY-1)*IW +: IW] : '0;
    assign rdata       = mem_q;
    assign lock_err    = lock_err_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;
endmodule

// File: tb/tb_s_mem_arbiter.sv
// tb_s_mem_arbiter: directed scoreboard bench for s_mem_arbiter with a behavioural
// registered-address RAM standing in for s_memory.
module tb_s_mem_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [2:0] req = '0, lock = '0, we = '0;
    logic [7:0] a [3];
    logic [7:0] d [3];
    logic [23:0] addr, wdata;
    logic [2:0] gnt, rvalid;
    logic [7:0] rdata, mem_address, mem_data, mem_q;
    logic lock_err, mem_wren;
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    logic [7:0] model [256];
    logic [7:0] ram [256];
    logic [7:0] ram_addr_r = '0;
    bit ram_init = 1'b0;
    typedef struct {int cyc; logic [2:0] rv; logic [7:0] data;} exp_t;
    exp_t sb [$];

    assign addr  = {a[2], a[1], a[0]};
    assign wdata = {d[2], d[1], d[0]};

    s_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .lock_err(lock_err), .mem_address(mem_address), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
            ram_init <= 1'b1;
        end else if (mem_wren) begin
            ram[mem_address] <= mem_data;
        end
        ram_addr_r <= mem_address;
    end
    assign mem_q = ram[ram_addr_r];

    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            assert (rvalid === e.rv && rdata === e.data)
            else begin
                fails++;
                $error("FAIL rdata cyc=%0d rvalid=%b rdata=%h exp rvalid=%b rdata=%h", cyc, rvalid, rdata, e.rv, e.data);
            end
        end else begin
            checks++;
            assert (rvalid === 3'b000)
            else begin
                fails++;
                $error("FAIL spurious_rvalid cyc=%0d rvalid=%b exp=000", cyc, rvalid);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w,
                         input logic [2:0] eg, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] wd, input string tag);
        @(negedge clk);
        req = r; lock = l; we = w;
        a[0] = a0; a[1] = a1; a[2] = a2;
        d[0] = wd; d[1] = wd; d[2] = wd;
        #1;
        chk(tag, 32'(gnt), 32'(eg));
        for (int i = 0; i < 3; i++) begin
            if (eg[i] && w[i]) model[a[i]] = wd;
            if (eg[i] && !w[i]) sb.push_back('{cyc + 2, 3'(1) << i, model[a[i]]});
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"}, 32'(mem_address), 0);
        chk({tag, "_data"}, 32'(mem_data), 0);
        chk({tag, "_wren"}, 32'(mem_wren), 0);
        chk({tag, "_rvalid"}, 32'(rvalid), 0);
        chk({tag, "_lockerr"}, 32'(lock_err), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = 8'(i);
        for (int i = 0; i < 3; i++) begin a[i] = '0; d[i] = '0; end
        repeat (3) @(negedge clk);
        check_zero("reset");
        chk("reset_gnt", 32'(gnt), 0);
        reset_n = 1'b1;
        // A read granted right before reset must never come back.
        @(negedge clk);
        req = 3'b001; a[0] = 8'h44; #1;
        chk("flight_gnt", 32'(gnt), 32'(3'b001));
        @(negedge clk);
        req = '0; reset_n = 1'b0; #1;
        check_zero("reset2");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        drive(3'b010, 3'b000, 3'b000, 3'b010, 8'h00, 8'h2A, 8'h00, 8'h00, "single_gnt");
        @(posedge clk); #1;
        chk("single_addr", 32'(mem_address), 32'h2A);
        chk("single_wren", 32'(mem_wren), 0);
        drive(3'b001, 3'b000, 3'b000, 3'b001, 8'h00, 8'h00, 8'h00, 8'h00, "ptr0_gnt");

        drive(3'b111, 3'b000, 3'b000, 3'b010, 8'h05, 8'h06, 8'h07, 8'h00, "rr1");
        drive(3'b111, 3'b000, 3'b000, 3'b100, 8'h05, 8'h06, 8'h07, 8'h00, "rr2");
        drive(3'b111, 3'b000, 3'b000, 3'b001, 8'h05, 8'h06, 8'h07, 8'h00, "rr3");
        drive(3'b111, 3'b000, 3'b000, 3'b010, 8'h05, 8'h06, 8'h07, 8'h00, "rr4");
        drive(3'b111, 3'b000, 3'b000, 3'b100, 8'h05, 8'h06, 8'h07, 8'h00, "rr5");
        drive(3'b111, 3'b000, 3'b000, 3'b001, 8'h05, 8'h06, 8'h07, 8'h00, "rr6");

        drive(3'b111, 3'b010, 3'b000, 3'b010, 8'h05, 8'h30, 8'h07, 8'h00, "swap_rd_i");
        drive(3'b111, 3'b010, 3'b000, 3'b010, 8'h05, 8'h31, 8'h07, 8'h00, "swap_rd_j");
        drive(3'b111, 3'b010, 3'b010, 3'b010, 8'h05, 8'h30, 8'h07, 8'h31, "swap_wr_i");
        drive(3'b111, 3'b000, 3'b010, 3'b010, 8'h05, 8'h31, 8'h07, 8'h30, "swap_wr_j");
        drive(3'b101, 3'b000, 3'b000, 3'b100, 8'h05, 8'h00, 8'h07, 8'h00, "swap_after2");
        drive(3'b101, 3'b000, 3'b000, 3'b001, 8'h05, 8'h00, 8'h07, 8'h00, "swap_after0");
        drive(3'b010, 3'b000, 3'b000, 3'b010, 8'h00, 8'h30, 8'h00, 8'h00, "swap_chk_i");
        drive(3'b010, 3'b000, 3'b000, 3'b010, 8'h00, 8'h31, 8'h00, 8'h00, "swap_chk_j");
        chk("swap_model_i", 32'(model[8'h30]), 32'h31);

        drive(3'b010, 3'b010, 3'b000, 3'b010, 8'h01, 8'h40, 8'h02, 8'h00, "wd_enter");
        for (int i = 0; i < 16; i++)
            drive(3'b111, 3'b010, 3'b000, 3'b010, 8'h01, 8'(8'h41 + i), 8'h02, 8'h00, "wd_hold");
        chk("wd_lockerr_pre", 32'(lock_err), 0);
        drive(3'b111, 3'b010, 3'b000, 3'b000, 8'h01, 8'h50, 8'h02, 8'h00, "wd_force");
        @(posedge clk); #1;
        chk("wd_lockerr", 32'(lock_err), 1);
        drive(3'b111, 3'b010, 3'b000, 3'b100, 8'h01, 8'h50, 8'h02, 8'h00, "wd_next2");
        drive(3'b111, 3'b010, 3'b000, 3'b001, 8'h01, 8'h50, 8'h02, 8'h00, "wd_next0");
        drive(3'b010, 3'b000, 3'b000, 3'b010, 8'h01, 8'h50, 8'h02, 8'h00, "wd_next1");

        drive(3'b001, 3'b000, 3'b001, 3'b001, 8'h10, 8'h00, 8'h00, 8'hA5, "mix_wr");
        drive(3'b001, 3'b000, 3'b000, 3'b001, 8'h10, 8'h00, 8'h00, 8'h00, "mix_rd");
        drive(3'b000, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, "idle");
        repeat (4) @(negedge clk);
        chk("lockerr_sticky", 32'(lock_err), 1);
        chk("drain", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
